coin_start_sequencer: RTL and testbench

//  Converts player start requests into the coin-then-start pulse sequence the arcade core

---
 rtl/arcade_input_pkg.sv | 16 +
 rtl/input_debounce.sv | 36 +++
 rtl/coin_start_sequencer.sv | 107 ++++++++++
 tb/tb_coin_start_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared state/player enums for the coin/start sequencer
package arcade_input_pkg;

  typedef enum logic [2:0] {IDLE, COIN, GAP, START, HOLD} state_t;
  typedef enum logic [1:0] {NONE, P1, P2} sel_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - 2-FF synchroniser plus ms-tick stability filter
module input_debounce #(
  parameter int DEB_MS = 5
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEB_MS + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Any agreement with the filtered level restarts the stability window.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_MS)) begin
        level <= sync[1];
        cnt   <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_start_sequencer.sv
// rtl/coin_start_sequencer.sv - debounced start/coin requests to timed coin-gap-start pulses
module coin_start_sequencer
  import arcade_input_pkg::*;
#(
  parameter int CLK_HZ   = 12_000_000,
  parameter int DEB_MS   = 5,
  parameter int COIN_MS  = 100,
  parameter int GAP_MS   = 200,
  parameter int START_MS = 100,
  parameter int HOLD_MS  = 500
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req_start1,
  input  logic req_start2,
  input  logic req_coin,
  output logic coin1,
  output logic start1,
  output logic start2,
  output logic busy
);

  localparam int CYC_MS = CLK_HZ / 1000;
  localparam int PW     = (CYC_MS > 1) ? $clog2(CYC_MS) : 1;
  localparam int MAX_MS = max4(COIN_MS, GAP_MS, START_MS, HOLD_MS);
  localparam int TW     = $clog2(MAX_MS * CYC_MS);

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(CYC_MS - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) pcnt <= '0;
    else          pcnt <= tick ? '0 : pcnt + 1'b1;
  end

  // Bit 0: player 1, bit 1: player 2, bit 2: coin button.
  logic [2:0] level, level_q, rise;

  input_debounce #(.DEB_MS(DEB_MS)) u_deb_start1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick), .raw(req_start1), .level(level[0])
  );
  input_debounce #(.DEB_MS(DEB_MS)) u_deb_start2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick), .raw(req_start2), .level(level[1])
  );
  input_debounce #(.DEB_MS(DEB_MS)) u_deb_coin (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick), .raw(req_coin), .level(level[2])
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) level_q <= '0;
    else          level_q <= level;
  end

  assign rise = level & ~level_q;

  state_t        state, nxt;
  sel_t          sel;
  logic [TW-1:0] timer;

  function automatic logic [TW-1:0] load(input state_t s);
    case (s)
      COIN:    return TW'(COIN_MS * CYC_MS - 1);
      GAP:     return TW'(GAP_MS * CYC_MS - 1);
      START:   return TW'(START_MS * CYC_MS - 1);
      HOLD:    return TW'(HOLD_MS * CYC_MS - 1);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|rise) nxt = COIN;
      COIN:    if (timer == '0) nxt = (sel != NONE) ? GAP : HOLD;
      GAP:     if (timer == '0) nxt = START;
      START:   if (timer == '0) nxt = HOLD;
      HOLD:    if (timer == '0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from nxt so they change on the same edge as the state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sel    <= NONE;
      timer  <= '0;
      coin1  <= 1'b0;
      start1 <= 1'b0;
      start2 <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == COIN)
        sel <= rise[0] ? P1 : (rise[1] ? P2 : NONE);
      if (nxt != state)       timer <= load(nxt);
      else if (timer != '0)   timer <= timer - 1'b1;
      coin1  <= (nxt == COIN);
      start1 <= (nxt == START) && (sel == P1);
      start2 <= (nxt == START) && (sel == P2);
      busy   <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_coin_start_sequencer.sv
// tb/tb_coin_start_sequencer.sv - randomized and directed checks against a schedule-based model
module tb_coin_start_sequencer;

  localparam int CLK_HZ = 10_000;
  localparam int CYC    = CLK_HZ / 1000;
  localparam int DEB    = 2;
  localparam int CC     = 3 * CYC;
  localparam int GC     = 2 * CYC;
  localparam int SC     = 3 * CYC;
  localparam int HC     = 4 * CYC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_start1 = 1'b0, req_start2 = 1'b0, req_coin = 1'b0;
  logic coin1, start1, start2, busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  coin_start_sequencer #(
    .CLK_HZ(CLK_HZ), .DEB_MS(DEB), .COIN_MS(3), .GAP_MS(2), .START_MS(3), .HOLD_MS(4)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .req_start1(req_start1), .req_start2(req_start2),
    .req_coin(req_coin), .coin1(coin1), .start1(start1), .start2(start2), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: debounced edges, then each accepted event books fixed output windows.
  int  k;
  bit  s1[3], s2[3], f[3], rose[3], ev[3], rawv[3];
  int  c[3];
  bit  tick;
  int  busy_end = -10, coin_lo = 1, coin_hi = 0, st_lo = 1, st_hi = 0, st_p = 0;
  logic [3:0] exp_out = 4'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k = 0;
      for (int i = 0; i < 3; i++) begin
        s1[i] = 0; s2[i] = 0; f[i] = 0; rose[i] = 0; c[i] = 0;
      end
      busy_end = -10; coin_lo = 1; coin_hi = 0; st_lo = 1; st_hi = 0; st_p = 0;
      exp_out = 4'b0;
    end else begin
      k = k + 1;
      tick = (k % CYC == 0);
      rawv[0] = req_start1; rawv[1] = req_start2; rawv[2] = req_coin;
      for (int i = 0; i < 3; i++) begin
        ev[i] = rose[i];
        rose[i] = 0;
        if (s2[i] == f[i]) c[i] = 0;
        else if (c[i] == DEB) begin f[i] = s2[i]; rose[i] = s2[i]; c[i] = 0; end
        else if (tick) c[i] = c[i] + 1;
        s2[i] = s1[i];
        s1[i] = rawv[i];
      end
      if (k - 1 > busy_end && (ev[0] || ev[1] || ev[2])) begin
        coin_lo = k;
        coin_hi = k + CC - 1;
        if (ev[0] || ev[1]) begin
          st_p = ev[0] ? 1 : 2;
          st_lo = k + CC + GC;
          st_hi = st_lo + SC - 1;
          busy_end = st_hi + HC;
        end else begin
          st_p = 0; st_lo = 1; st_hi = 0;
          busy_end = coin_hi + HC;
        end
      end
      exp_out = {(k >= coin_lo && k <= coin_hi),
                 (st_p == 1 && k >= st_lo && k <= st_hi),
                 (st_p == 2 && k >= st_lo && k <= st_hi),
                 (k >= coin_lo && k <= busy_end)};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks = checks + 1;
      if ({coin1, start1, start2, busy} !== exp_out) begin
        errors = errors + 1;
        $display("FAIL model_cmp t=%0t got coin1,start1,start2,busy=%b required=%b",
                 $time, {coin1, start1, start2, busy}, exp_out);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  function automatic bit sig(input int w);
    case (w)
      0:       return coin1;
      1:       return start1 | start2;
      default: return busy;
    endcase
  endfunction

  task automatic run_len(input int w, input bit val, output int n);
    n = 0;
    while (sig(w) == val && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_coin(output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (coin1) ok = 1;
    end
  endtask

  task automatic measure_seq(input string tag, input int player, input bit rel_on_coin,
                             input bit press2_in_gap);
    bit ok;
    int n;
    wait_coin(ok);
    check({tag, "_coin_rise"}, ok, 1);
    if (!ok) return;
    if (rel_on_coin) begin req_start1 = 0; req_start2 = 0; req_coin = 0; end
    run_len(0, 1, n);
    check({tag, "_coin_len"}, n, 30);
    if (player != 0) begin
      if (press2_in_gap) req_start2 = 1;
      run_len(1, 0, n);
      check({tag, "_gap_len"}, n, 20);
      check({tag, "_start_sel"}, {start1, start2}, (player == 1) ? 2 : 1);
      run_len(1, 1, n);
      check({tag, "_start_len"}, n, 30);
    end
    run_len(2, 1, n);
    check({tag, "_hold_len"}, n, 40);
  endtask

  task automatic idle_cycles(input string tag, input int cyc);
    int hi;
    hi = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (busy) hi++;
    end
    check({tag, "_busy_cycles"}, hi, 0);
  endtask

  initial begin
    bit ok;
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_outputs", {coin1, start1, start2, busy}, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);

    // 1: player 1 held
    req_start1 = 1;
    measure_seq("t1", 1, 0, 0);
    req_start1 = 0;
    idle_cycles("t1_after", 50);

    // 2: short glitch cannot span two ms ticks
    req_start1 = 1;
    repeat (9) @(negedge clk);
    req_start1 = 0;
    idle_cycles("t2_glitch", 60);

    // 3: both players in the same cycle
    req_start1 = 1; req_start2 = 1;
    measure_seq("t3", 1, 1, 0);
    idle_cycles("t3_after", 40);

    // 4: coin button only
    req_coin = 1;
    measure_seq("t4", 0, 1, 0);
    idle_cycles("t4_after", 40);

    // 5: start2 pressed during gap, held through hold, then re-pressed
    req_start1 = 1;
    measure_seq("t5a", 1, 1, 1);
    idle_cycles("t5_held", 60);
    req_start2 = 0;
    repeat (40) @(negedge clk);
    req_start2 = 1;
    measure_seq("t5b", 2, 1, 0);
    idle_cycles("t5_after", 40);

    // 6: asynchronous reset during start
    req_start1 = 1;
    wait_coin(ok);
    check("t6_coin_rise", ok, 1);
    req_start1 = 0;
    run_len(0, 1, n);
    run_len(1, 0, n);
    check("t6_start_high", start1, 1);
    @(posedge clk);
    #3 reset_n = 0;
    #1 check("t6_async_drop", {coin1, start1, start2, busy}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    check("t6_after_release", {coin1, start1, start2, busy}, 0);
    idle_cycles("t6_idle", 40);

    // Randomized request traffic, checked cycle by cycle against the model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0:       req_start1 = ~req_start1;
        1:       req_start2 = ~req_start2;
        2:       req_coin   = ~req_coin;
        default: begin req_start1 = 0; req_start2 = 0; req_coin = 0; end
      endcase
      repeat ($urandom_range(1, 45)) @(negedge clk);
    end
    req_start1 = 0; req_start2 = 0; req_coin = 0;
    repeat (250) @(negedge clk);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
